// File: rtl/joypad_poller.sv
// NES joypad host reader: drives latch/clock to the controller shift register and returns the button byte.
// Optional macro JOYPAD_SIG_CHECK_EN reads 24 bits and validates the 16-bit standard-controller signature.
module joypad_poller #(
  parameter int LATCH_CYCLES    = 4,
  parameter int HALF            = 2,
  parameter bit DATA_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       poll_req,
  input  logic       joypad_data,
  output logic       joypad_latch,
  output logic       joypad_clk,
  output logic [7:0] buttons,
  output logic       buttons_valid,
  output logic       busy,
  output logic       sig_err,
  output logic [2:0] dbg_state
);

`ifdef JOYPAD_SIG_CHECK_EN
  localparam int N = 24;
`else
  localparam int N = 8;
`endif
  localparam int MAXC = (LATCH_CYCLES > HALF) ? LATCH_CYCLES : HALF;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = $clog2(N);

  localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_LOW   = 3'd2,
    S_HIGH  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Handshake: poll_req is a level/pulse request taken only while idle (busy low);
  // buttons_valid is a one-cycle strobe with no ready, so consumers must capture buttons then.
  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [IW-1:0]   idx, idx_n;
  logic [N-1:0]    cap, cap_n;
  logic            sync1, sync2;
  logic            latch_n, jclk_n, busy_n, valid_n;
  logic [7:0]      buttons_n;
`ifdef JOYPAD_SIG_CHECK_EN
  logic            sig_err_q, sig_err_n;
`endif

  assign dbg_state = state;

  // Two-flop synchronizer for the asynchronous controller data line.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= joypad_data;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      idx           <= '0;
      cap           <= '0;
      joypad_latch  <= 1'b0;
      joypad_clk    <= 1'b0;
      busy          <= 1'b0;
      buttons_valid <= 1'b0;
      buttons       <= 8'h00;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      idx           <= idx_n;
      cap           <= cap_n;
      joypad_latch  <= latch_n;
      joypad_clk    <= jclk_n;
      busy          <= busy_n;
      buttons_valid <= valid_n;
      buttons       <= buttons_n;
    end
  end

`ifdef JOYPAD_SIG_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) sig_err_q <= 1'b0;
    else     sig_err_q <= sig_err_n;
  end
  assign sig_err = sig_err_q;
`else
  assign sig_err = 1'b0;
`endif

  // Outputs are computed for the upcoming state and registered, so the pins
  // change on the same edge the FSM enters the corresponding phase.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    idx_n     = idx;
    cap_n     = cap;
    latch_n   = 1'b0;
    jclk_n    = 1'b0;
    busy_n    = 1'b1;
    valid_n   = 1'b0;
    buttons_n = buttons;
`ifdef JOYPAD_SIG_CHECK_EN
    sig_err_n = sig_err_q;
`endif
    case (state)
      S_IDLE: begin
        cnt_n  = '0;
        busy_n = 1'b0;
        if (poll_req) begin
          state_n = S_LATCH;
          busy_n  = 1'b1;
          latch_n = 1'b1;
        end
      end
      S_LATCH: begin
        latch_n = 1'b1;
        if (cnt == LATCH_LAST) begin
          state_n = S_LOW;
          cnt_n   = '0;
          idx_n   = '0;
          latch_n = 1'b0;
        end
      end
      S_LOW: begin
        if (cnt == HALF_LAST) begin
          // Late in the low phase so the post-edge data has cleared the synchronizer.
          cap_n[idx] = sync2 ^ DATA_ACTIVE_LOW;
          state_n    = S_HIGH;
          cnt_n      = '0;
          jclk_n     = 1'b1;
        end
      end
      S_HIGH: begin
        jclk_n = 1'b1;
        if (cnt == HALF_LAST) begin
          cnt_n  = '0;
          jclk_n = 1'b0;
          if (idx == IDX_LAST) begin
            state_n = S_DONE;
            valid_n = 1'b1;
`ifdef JOYPAD_SIG_CHECK_EN
            if (cap[N-1:8] == 16'hF100) begin
              buttons_n = cap[7:0];
              sig_err_n = 1'b0;
            end else begin
              sig_err_n = 1'b1;
            end
`else
            buttons_n = cap[7:0];
`endif
          end else begin
            idx_n   = idx + IW'(1);
            state_n = S_LOW;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
        cnt_n   = '0;
        idx_n   = '0;
      end
      default: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
        cnt_n   = '0;
        idx_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_joypad_poller.sv
// Bench for joypad_poller: behavioural controller shift-register models feed two instances
// (normal and active-low polarity); expected button bytes flow through scoreboard queues.
module tb_joypad_poller;
  localparam int L = 4;
  localparam int H = 2;
`ifdef JOYPAD_SIG_CHECK_EN
  localparam int NW = 24;
`else
  localparam int NW = 8;
`endif
  localparam int TOTAL = 1 + L + 2 * H * NW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic poll_req = 1'b0;
  logic poll_req_al = 1'b0;

  logic       data, latch, jclk, valid, busy, sig_err;
  logic [7:0] buttons;
  logic [2:0] dbg;
  logic       data_al, latch_al, jclk_al, valid_al, busy_al, sig_err_al;
  logic [7:0] buttons_al;
  logic [2:0] dbg_al;

  int n_total = 0;
  int n_pass  = 0;
  int v_count = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_al_q[$];

  always #5 clk = ~clk;

  joypad_poller #(.LATCH_CYCLES(L), .HALF(H), .DATA_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .poll_req(poll_req), .joypad_data(data),
    .joypad_latch(latch), .joypad_clk(jclk), .buttons(buttons),
    .buttons_valid(valid), .busy(busy), .sig_err(sig_err), .dbg_state(dbg)
  );

  joypad_poller #(.LATCH_CYCLES(L), .HALF(H), .DATA_ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .poll_req(poll_req_al), .joypad_data(data_al),
    .joypad_latch(latch_al), .joypad_clk(jclk_al), .buttons(buttons_al),
    .buttons_valid(valid_al), .busy(busy_al), .sig_err(sig_err_al), .dbg_state(dbg_al)
  );

  // Controller models: parallel load while latch is high, shift right on each rising clock.
  logic [NW-1:0] load = '0;
  logic [NW-1:0] load_al = '0;
  logic [NW-1:0] sh = '1;
  logic [NW-1:0] sh_al = '1;
  logic prev_jclk = 1'b0;
  logic prev_jclk_al = 1'b0;

  always @(negedge clk) begin
    if (latch) sh <= load;
    else if (jclk && !prev_jclk) sh <= {1'b1, sh[NW-1:1]};
    prev_jclk <= jclk;
    if (latch_al) sh_al <= load_al;
    else if (jclk_al && !prev_jclk_al) sh_al <= {1'b1, sh_al[NW-1:1]};
    prev_jclk_al <= jclk_al;
  end
  assign data    = sh[0];
  assign data_al = sh_al[0];

  always @(negedge clk) if (valid) v_count++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog");
  end

  function automatic logic [NW-1:0] mk(input logic [7:0] b);
`ifdef JOYPAD_SIG_CHECK_EN
    return {16'hF100, b};
`else
    return b;
`endif
  endfunction

  int         obs_lat_first, obs_lat_last, obs_busy_first, obs_busy_last;
  int         obs_valid_at, obs_valid_n, obs_pulses;
  logic [7:0] obs_btn;
  logic       obs_serr;

  task automatic start_poll;
    @(posedge clk); #1 poll_req = 1'b1;
    @(posedge clk); #1 poll_req = 1'b0;
  endtask

  // Records the waveform of one poll relative to the accepting edge (cycle 1 follows it).
  task automatic observe_poll(input int ncyc);
    logic pj;
    pj = 1'b0;
    obs_lat_first = -1; obs_lat_last = -1; obs_busy_first = -1; obs_busy_last = -1;
    obs_valid_at = -1; obs_valid_n = 0; obs_pulses = 0; obs_btn = 8'hxx; obs_serr = 1'bx;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (latch) begin if (obs_lat_first < 0) obs_lat_first = k; obs_lat_last = k; end
      if (busy) begin if (obs_busy_first < 0) obs_busy_first = k; obs_busy_last = k; end
      if (jclk && !pj) obs_pulses++;
      pj = jclk;
      if (valid) begin obs_valid_n++; obs_valid_at = k; obs_btn = buttons; obs_serr = sig_err; end
    end
  endtask

  task automatic test_reset;
    int bad, v0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++; if (latch !== 1'b0) $display("FAIL rst_latch: got %b want 0", latch); else n_pass++;
    n_total++; if (jclk !== 1'b0) $display("FAIL rst_jclk: got %b want 0", jclk); else n_pass++;
    n_total++; if (buttons !== 8'h00) $display("FAIL rst_buttons: got %h want 00", buttons); else n_pass++;
    n_total++; if (valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (sig_err !== 1'b0) $display("FAIL rst_sig_err: got %b want 0", sig_err); else n_pass++;
    rst = 1'b0;
    bad = 0;
    v0 = v_count;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (latch !== 1'b0 || jclk !== 1'b0 || busy !== 1'b0 || valid !== 1'b0 || buttons !== 8'h00) bad++;
    end
    n_total++; if (bad !== 0) $display("FAIL idle_quiet: got %0d bad cycles want 0", bad); else n_pass++;
    n_total++; if (v_count !== v0) $display("FAIL idle_valid: got %0d pulses want 0", v_count - v0); else n_pass++;
  endtask

  task automatic test_basic;
    logic [7:0] e;
    load = mk(8'hA5);
    exp_q.push_back(8'hA5);
    start_poll();
    observe_poll(TOTAL + 3);
    n_total++; if (obs_lat_first !== 1) $display("FAIL latch_rise: got %0d want 1", obs_lat_first); else n_pass++;
    n_total++; if (obs_lat_last !== L) $display("FAIL latch_fall: got %0d want %0d", obs_lat_last, L); else n_pass++;
    n_total++; if (obs_busy_first !== 1) $display("FAIL busy_rise: got %0d want 1", obs_busy_first); else n_pass++;
    n_total++; if (obs_busy_last !== TOTAL) $display("FAIL busy_fall: got %0d want %0d", obs_busy_last, TOTAL); else n_pass++;
    n_total++; if (obs_pulses !== NW) $display("FAIL clk_pulses: got %0d want %0d", obs_pulses, NW); else n_pass++;
    n_total++; if (obs_valid_at !== TOTAL) $display("FAIL valid_cycle: got %0d want %0d", obs_valid_at, TOTAL); else n_pass++;
    n_total++; if (obs_valid_n !== 1) $display("FAIL valid_count: got %0d want 1", obs_valid_n); else n_pass++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_total++; if (obs_btn !== e) $display("FAIL basic_buttons: got %h want %h", obs_btn, e); else n_pass++;
  endtask

  task automatic test_active_low;
    logic       seen;
    int         at;
    logic [7:0] btn, e;
    load_al = ~mk(8'hC3);
    exp_al_q.push_back(8'hC3);
    @(posedge clk); #1 poll_req_al = 1'b1;
    @(posedge clk); #1 poll_req_al = 1'b0;
    seen = 1'b0; at = -1; btn = 8'hxx;
    for (int k = 1; k <= TOTAL + 5; k++) begin
      @(negedge clk);
      if (valid_al && !seen) begin seen = 1'b1; at = k; btn = buttons_al; end
    end
    n_total++; if (seen !== 1'b1) $display("FAIL al_timeout: got %b want 1", seen); else n_pass++;
    n_total++; if (at !== TOTAL) $display("FAIL al_valid_cycle: got %0d want %0d", at, TOTAL); else n_pass++;
    e = (exp_al_q.size() > 0) ? exp_al_q.pop_front() : 8'hxx;
    n_total++; if (btn !== e) $display("FAIL al_buttons: got %h want %h", btn, e); else n_pass++;
    n_total++; if (sig_err_al !== 1'b0) $display("FAIL al_sig_err: got %b want 0", sig_err_al); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int         rises[$];
    int         valids[$];
    logic       pl;
    logic [7:0] e;
    load = mk(8'h69);
    pl = 1'b0;
    @(posedge clk); #1 poll_req = 1'b1;
    for (int k = 1; k <= 3 * (TOTAL + 1) + 2; k++) begin
      @(negedge clk);
      if (latch && !pl) begin rises.push_back(k); exp_q.push_back(8'h69); end
      pl = latch;
      if (valid) begin
        valids.push_back(k);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_total++; if (buttons !== e) $display("FAIL b2b_buttons: got %h want %h", buttons, e); else n_pass++;
      end
    end
    poll_req = 1'b0;
    for (int k = 0; k < TOTAL + 5; k++) begin
      @(negedge clk);
      if (valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_total++; if (buttons !== e) $display("FAIL b2b_drain_buttons: got %h want %h", buttons, e); else n_pass++;
      end
    end
    n_total++; if (rises.size() < 3) $display("FAIL b2b_polls: got %0d want 3+", rises.size()); else n_pass++;
    n_total++;
    if (rises.size() >= 2 && valids.size() >= 2 && valids[0] - rises[0] == TOTAL - 1 && rises[1] - valids[0] == 2)
      n_pass++;
    else
      $display("FAIL b2b_spacing: got rises=%0d valids=%0d want valid-latch=%0d latch-valid=2", rises.size(), valids.size(), TOTAL - 1);
    n_total++;
    if (rises.size() >= 3 && valids.size() >= 2 && rises[2] - rises[1] == TOTAL + 1) n_pass++;
    else $display("FAIL b2b_period: got %0d polls want period %0d", rises.size(), TOTAL + 1);
    n_total++; if (exp_q.size() !== 0) $display("FAIL b2b_leftover: got %0d want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_busy_drop;
    int         v0, nrise, at;
    logic       pl;
    logic [7:0] btn, e;
    load = mk(8'h12);
    exp_q.push_back(8'h12);
    v0 = v_count; nrise = 0; at = -1; pl = 1'b0; btn = 8'hxx;
    start_poll();
    for (int k = 1; k <= TOTAL + 12; k++) begin
      @(negedge clk);
      if (latch && !pl) nrise++;
      pl = latch;
      if (valid) begin at = k; btn = buttons; end
      if (k == 10 || k == TOTAL) poll_req = 1'b1;
      if (k == 11 || k == TOTAL + 1) poll_req = 1'b0;
    end
    n_total++; if (nrise !== 1) $display("FAIL drop_latches: got %0d want 1", nrise); else n_pass++;
    n_total++; if (v_count - v0 !== 1) $display("FAIL drop_valids: got %0d want 1", v_count - v0); else n_pass++;
    n_total++; if (at !== TOTAL) $display("FAIL drop_valid_cycle: got %0d want %0d", at, TOTAL); else n_pass++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_total++; if (btn !== e) $display("FAIL drop_buttons: got %h want %h", btn, e); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL drop_busy_end: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_mid_reset;
    logic [7:0] e;
    load = mk(8'h3F);
    start_poll();
    for (int k = 1; k <= 19; k++) @(negedge clk);
    n_total++; if (jclk !== 1'b1) $display("FAIL mid_pulse4_high: got %b want 1", jclk); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_total++; if (latch !== 1'b0) $display("FAIL mid_latch: got %b want 0", latch); else n_pass++;
    n_total++; if (jclk !== 1'b0) $display("FAIL mid_jclk: got %b want 0", jclk); else n_pass++;
    n_total++; if (buttons !== 8'h00) $display("FAIL mid_buttons: got %h want 00", buttons); else n_pass++;
    n_total++; if (valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (sig_err !== 1'b0) $display("FAIL mid_sig_err: got %b want 0", sig_err); else n_pass++;
    rst = 1'b0;
    load = mk(8'h81);
    exp_q.push_back(8'h81);
    start_poll();
    observe_poll(TOTAL + 3);
    n_total++; if (obs_valid_at !== TOTAL) $display("FAIL post_rst_valid: got %0d want %0d", obs_valid_at, TOTAL); else n_pass++;
    n_total++; if (obs_pulses !== NW) $display("FAIL post_rst_pulses: got %0d want %0d", obs_pulses, NW); else n_pass++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_total++; if (obs_btn !== e) $display("FAIL post_rst_buttons: got %h want %h", obs_btn, e); else n_pass++;
  endtask

`ifdef JOYPAD_SIG_CHECK_EN
  task automatic test_signature;
    logic [7:0] e;
    load = {16'hF100, 8'h5A};
    exp_q.push_back(8'h5A);
    start_poll();
    observe_poll(TOTAL + 3);
    n_total++; if (obs_valid_at !== 101) $display("FAIL sig_valid_cycle: got %0d want 101", obs_valid_at); else n_pass++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_total++; if (obs_btn !== e) $display("FAIL sig_ok_buttons: got %h want %h", obs_btn, e); else n_pass++;
    n_total++; if (obs_serr !== 1'b0) $display("FAIL sig_ok_err: got %b want 0", obs_serr); else n_pass++;
    load = {16'hFF00, 8'h77};
    exp_q.push_back(8'h5A);
    start_poll();
    observe_poll(TOTAL + 3);
    n_total++; if (obs_valid_n !== 1) $display("FAIL sig_bad_valid: got %0d want 1", obs_valid_n); else n_pass++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_total++; if (obs_btn !== e) $display("FAIL sig_bad_buttons: got %h want %h", obs_btn, e); else n_pass++;
    n_total++; if (obs_serr !== 1'b1) $display("FAIL sig_bad_err: got %b want 1", obs_serr); else n_pass++;
    repeat (5) @(negedge clk);
    n_total++; if (sig_err !== 1'b1) $display("FAIL sig_err_hold: got %b want 1", sig_err); else n_pass++;
  endtask
`else
  task automatic test_signature;
    n_total++; if (sig_err !== 1'b0) $display("FAIL sig_tied: got %b want 0", sig_err); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_active_low();
    test_back_to_back();
    test_busy_drop();
    test_mid_reset();
    test_signature();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
